// File: rtl/conv3x3_bank.sv
// conv3x3_bank: 3x3 convolution engine with LANES parallel output-channel PEs.
// Each accepted window is multiplied against the weights of the channels
// selected by the current group; results appear three cycles later.
module conv3x3_bank #(
    parameter int WI    = 8,
    parameter int BW    = 32,
    parameter int ACCW  = 32,
    parameter int LANES = 4,
    parameter int OC    = 16,
    localparam int NG   = OC / LANES,
    localparam int GW   = (NG > 1) ? $clog2(NG) : 1,
    localparam int WAW  = $clog2(OC * 9),
    localparam int BAW  = $clog2(OC)
) (
    input  logic                  iClk,
    input  logic                  iRsn,
    input  logic [3*WI-1:0]       iWindowInRow1,
    input  logic [3*WI-1:0]       iWindowInRow2,
    input  logic [3*WI-1:0]       iWindowInRow3,
    input  logic                  iInValid,
    input  logic                  iMapDone,
    input  logic                  iReluEn,
    input  logic                  iWeWr,
    input  logic [WAW-1:0]        iWeAddr,
    input  logic [WI-1:0]         iWeData,
    input  logic                  iBiWr,
    input  logic [BAW-1:0]        iBiAddr,
    input  logic [BW-1:0]         iBiData,
    output logic [LANES-1:0]      oValid,
    output logic [LANES*ACCW-1:0] oData,
    output logic [GW-1:0]         oGroup,
    output logic                  oLayerDone
);

    generate
        if (OC % LANES != 0) begin : g_bad_oc
            $error("conv3x3_bank: OC must be a multiple of LANES");
        end
    endgenerate

    // Coefficient storage (not reset, contents survive iRsn)
    logic signed [WI-1:0]   r_weight [OC][9];
    logic signed [BW-1:0]   r_bias   [OC];

    // Control
    logic                   r_run;
    logic [GW-1:0]          r_group;
    logic                   r_layerDone;

    // Stage 1
    logic signed [2*WI-1:0] r_s1Prod [LANES][9];
    logic signed [ACCW-1:0] r_s1Bias [LANES];
    logic                   r_s1Valid;
    logic [GW-1:0]          r_s1Group;
    logic                   r_s1Relu;

    // Stage 2
    logic signed [ACCW-1:0] r_s2Sum [LANES];
    logic                   r_s2Valid;
    logic [GW-1:0]          r_s2Group;
    logic                   r_s2Relu;

    // Stage 3 / outputs
    logic [LANES-1:0]       r_oValid;
    logic [LANES*ACCW-1:0]  r_oData;
    logic [GW-1:0]          r_oGroup;

    // Combinational helpers
    logic signed [WI-1:0]   w_pix [9];
    logic [BAW-1:0]         w_ch  [LANES];
    logic signed [ACCW-1:0] w_sum [LANES];
    logic                   w_accept;
    logic                   w_mapTake;
    logic                   w_lastGroup;

    assign w_accept    = iInValid & r_run;
    assign w_mapTake   = iMapDone & r_run;
    assign w_lastGroup = (r_group == GW'(NG - 1));

    // Unpack window rows (MSB slice is column 0) and map lanes to channels
    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            w_pix[c]     = iWindowInRow1[(2 - c)*WI +: WI];
            w_pix[3 + c] = iWindowInRow2[(2 - c)*WI +: WI];
            w_pix[6 + c] = iWindowInRow3[(2 - c)*WI +: WI];
        end
        for (int unsigned l = 0; l < LANES; l++) begin
            w_ch[l] = BAW'(32'(r_group) * LANES + l);
        end
    end

    // Nine-term sum plus bias, wrapping at ACCW bits
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            w_sum[l] = r_s1Bias[l];
            for (int unsigned k = 0; k < 9; k++) begin
                w_sum[l] = w_sum[l] + ACCW'(r_s1Prod[l][k]);
            end
        end
    end

    // Weight and bias register file; addresses beyond OC*9 / OC match nothing
    always_ff @(posedge iClk) begin
        for (int unsigned ch = 0; ch < OC; ch++) begin
            for (int unsigned k = 0; k < 9; k++) begin
                if (iWeWr && (iWeAddr == WAW'(ch*9 + k))) begin
                    r_weight[ch][k] <= iWeData;
                end
            end
            if (iBiWr && (iBiAddr == BAW'(ch))) begin
                r_bias[ch] <= iBiData;
            end
        end
    end

    // Reset release qualifier, group counter and layer-done pulse
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_run       <= 1'b0;
            r_group     <= '0;
            r_layerDone <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_layerDone <= w_mapTake & w_lastGroup;
            if (w_mapTake) begin
                r_group <= w_lastGroup ? '0 : r_group + 1'b1;
            end
        end
    end

    // Datapath stages 1-2: products and coefficients are captured at acceptance,
    // so later coefficient writes never reach windows already in flight
    always_ff @(posedge iClk) begin
        if (w_accept) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                for (int unsigned k = 0; k < 9; k++) begin
                    r_s1Prod[l][k] <= (2*WI)'(w_pix[k]) * (2*WI)'(r_weight[w_ch[l]][k]);
                end
                r_s1Bias[l] <= ACCW'(r_bias[w_ch[l]]);
            end
        end
        if (r_s1Valid) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                r_s2Sum[l] <= w_sum[l];
            end
        end
    end

    // Pipeline valids, tags and the ReLU output stage
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_s1Valid <= 1'b0;
            r_s1Group <= '0;
            r_s1Relu  <= 1'b0;
            r_s2Valid <= 1'b0;
            r_s2Group <= '0;
            r_s2Relu  <= 1'b0;
            r_oValid  <= '0;
            r_oData   <= '0;
            r_oGroup  <= '0;
        end else begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1Group <= r_group;
                r_s1Relu  <= iReluEn;
            end
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Group <= r_s1Group;
                r_s2Relu  <= r_s1Relu;
            end
            r_oValid <= {LANES{r_s2Valid}};
            if (r_s2Valid) begin
                r_oGroup <= r_s2Group;
                for (int unsigned l = 0; l < LANES; l++) begin
                    r_oData[l*ACCW +: ACCW] <= (r_s2Relu && r_s2Sum[l][ACCW-1]) ? '0 : r_s2Sum[l];
                end
            end
        end
    end

    assign oValid     = r_oValid;
    assign oData      = r_oData;
    assign oGroup     = r_oGroup;
    assign oLayerDone = r_layerDone;

endmodule

// File: tb/tb_conv3x3_bank.sv
// Testbench for conv3x3_bank: randomized windows and coefficient writes
// against an arithmetic reference model, checked through a scoreboard queue.
module tb_conv3x3_bank;

    localparam int WI    = 8;
    localparam int BW    = 32;
    localparam int ACCW  = 32;
    localparam int LANES = 4;
    localparam int OC    = 16;
    localparam int NG    = OC / LANES;
    localparam int GW    = 2;
    localparam int WAW   = 8;
    localparam int BAW   = 4;
    localparam int DW    = LANES * ACCW;
    localparam int RAND  = -1000;

    logic                 clk = 1'b0;
    logic                 iRsn;
    logic [3*WI-1:0]      iWindowInRow1, iWindowInRow2, iWindowInRow3;
    logic                 iInValid, iMapDone, iReluEn;
    logic                 iWeWr;
    logic [WAW-1:0]       iWeAddr;
    logic [WI-1:0]        iWeData;
    logic                 iBiWr;
    logic [BAW-1:0]       iBiAddr;
    logic [BW-1:0]        iBiData;
    logic [LANES-1:0]     oValid;
    logic [DW-1:0]        oData;
    logic [GW-1:0]        oGroup;
    logic                 oLayerDone;

    always #5 clk = ~clk;

    conv3x3_bank #(.WI(WI), .BW(BW), .ACCW(ACCW), .LANES(LANES), .OC(OC)) dut (
        .iClk(clk), .iRsn(iRsn),
        .iWindowInRow1(iWindowInRow1), .iWindowInRow2(iWindowInRow2), .iWindowInRow3(iWindowInRow3),
        .iInValid(iInValid), .iMapDone(iMapDone), .iReluEn(iReluEn),
        .iWeWr(iWeWr), .iWeAddr(iWeAddr), .iWeData(iWeData),
        .iBiWr(iBiWr), .iBiAddr(iBiAddr), .iBiData(iBiData),
        .oValid(oValid), .oData(oData), .oGroup(oGroup), .oLayerDone(oLayerDone)
    );

    // Reference model state
    int mw [OC*9];
    int mb [OC];
    int mgroup   = 0;
    bit prev_rsn = 1'b0;

    typedef struct {
        logic [DW-1:0] data;
        int            group;
        int            due;
    } exp_t;
    exp_t sq [$];
    int   ldq [$];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Per-step stimulus fields
    bit s_rsn, s_v, s_md, s_relu, s_we, s_be;
    int s_wa, s_wd, s_ba, s_bd, s_fix;

    task automatic clr();
        s_rsn = 1'b1; s_v = 1'b0; s_md = 1'b0; s_relu = 1'b0;
        s_we = 1'b0; s_be = 1'b0; s_wa = 0; s_wd = 0; s_ba = 0; s_bd = 0;
        s_fix = RAND;
    endtask

    // Drive one cycle of stimulus, update the model, advance one clock
    task automatic step();
        int p [9];
        int s, ch;
        logic [DW-1:0] e;
        exp_t t;
        bit acc;
        for (int k = 0; k < 9; k++)
            p[k] = (s_fix == RAND) ? int'($urandom_range(0, 255)) - 128 : s_fix;
        iRsn          = s_rsn;
        iInValid      = s_v;
        iMapDone      = s_md;
        iReluEn       = s_relu;
        iWindowInRow1 = {WI'(p[0]), WI'(p[1]), WI'(p[2])};
        iWindowInRow2 = {WI'(p[3]), WI'(p[4]), WI'(p[5])};
        iWindowInRow3 = {WI'(p[6]), WI'(p[7]), WI'(p[8])};
        iWeWr = s_we; iWeAddr = WAW'(s_wa); iWeData = WI'(s_wd);
        iBiWr = s_be; iBiAddr = BAW'(s_ba); iBiData = BW'(s_bd);
        acc = s_rsn && prev_rsn;
        if (acc && s_v) begin
            for (int l = 0; l < LANES; l++) begin
                ch = mgroup * LANES + l;
                s  = mb[ch];
                for (int k = 0; k < 9; k++) s += p[k] * mw[ch*9 + k];
                if (s_relu && s < 0) s = 0;
                e[l*ACCW +: ACCW] = s;
            end
            t.data = e; t.group = mgroup; t.due = cyc + 3;
            sq.push_back(t);
        end
        if (acc && s_md) begin
            if (mgroup == NG - 1) begin
                ldq.push_back(cyc + 1);
                mgroup = 0;
            end else begin
                mgroup++;
            end
        end
        if (s_we && s_wa < OC*9) mw[s_wa] = s_wd;
        if (s_be) mb[s_ba] = s_bd;
        prev_rsn = s_rsn;
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle: everything in flight is dropped
    task automatic reset_now();
        iRsn     = 1'b0;
        prev_rsn = 1'b0;
        mgroup   = 0;
        sq.delete();
        ldq.delete();
        #1;
        check("rst_oValid", oValid, '0);
        check("rst_oData", oData, '0);
        check("rst_oGroup", oGroup, '0);
        check("rst_oLayerDone", oLayerDone, '0);
    endtask

    // Monitor: pop the scoreboard whenever the DUT presents a result
    exp_t mt;
    bit   lde;
    always @(negedge clk) begin
        if (oValid !== '0) begin
            if (sq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output @cyc %0d: oValid=%b with no result pending", cyc, oValid);
            end else begin
                mt = sq.pop_front();
                check("valid_all_lanes", oValid, {LANES{1'b1}});
                check("latency", cyc, mt.due);
                check("data", oData, mt.data);
                check("group", oGroup, mt.group);
            end
        end
        lde = (ldq.size() > 0) && (ldq[0] == cyc);
        if (lde) void'(ldq.pop_front());
        if (lde || oLayerDone !== 1'b0) check("layer_done", oLayerDone, lde);
    end

    initial begin
        iRsn = 1'b1; iInValid = 1'b0; iMapDone = 1'b0; iReluEn = 1'b0;
        iWeWr = 1'b0; iBiWr = 1'b0; iWeAddr = '0; iWeData = '0; iBiAddr = '0; iBiData = '0;
        iWindowInRow1 = '0; iWindowInRow2 = '0; iWindowInRow3 = '0;
        #1 iRsn = 1'b0;
        @(negedge clk);
        check("init_oValid", oValid, '0);
        check("init_oData", oData, '0);
        check("init_oGroup", oGroup, '0);
        check("init_oLayerDone", oLayerDone, '0);
        @(posedge clk); #1;

        // Load all weights 1 and biases 0; bias writes share cycles with weight writes
        for (int a = 0; a < OC*9; a++) begin
            clr(); s_we = 1; s_wa = a; s_wd = 1;
            if (a < OC) begin s_be = 1; s_ba = a; s_bd = 0; end
            step();
        end

        // All pixels 2 -> each lane 18, group 0
        clr(); s_v = 1; s_fix = 2; step();
        repeat (3) begin clr(); step(); end

        // Channel 5: weights -1, bias 3
        for (int k = 0; k < 9; k++) begin
            clr(); s_we = 1; s_wa = 45 + k; s_wd = -1;
            if (k == 0) begin s_be = 1; s_ba = 5; s_bd = 3; end
            step();
        end
        clr(); s_md = 1; step();
        clr(); s_v = 1; s_fix = 1; s_relu = 0; step();
        clr(); s_v = 1; s_fix = 1; s_relu = 1; step();

        // Walk remaining groups 2,3 then wrap to 0 with layer done
        repeat (3) begin
            clr(); s_md = 1; step();
            clr(); s_v = 1; step();
        end

        // Window with iMapDone in the same cycle keeps the old group
        clr(); s_v = 1; s_md = 1; step();
        clr(); s_v = 1; step();

        // Randomized traffic, coefficient writes interleaved with windows
        for (int i = 0; i < 400; i++) begin
            clr();
            s_v    = ($urandom_range(0, 3) != 0);
            s_md   = ($urandom_range(0, 7) == 0);
            s_relu = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                s_we = 1; s_wa = $urandom_range(0, 255); s_wd = int'($urandom_range(0, 255)) - 128;
            end
            if ($urandom_range(0, 5) == 0) begin
                s_be = 1; s_ba = $urandom_range(0, OC - 1); s_bd = int'($urandom);
            end
            step();
        end

        // Back-to-back windows with reset after the fifth
        repeat (5) begin clr(); s_v = 1; s_relu = $urandom_range(0, 1); step(); end
        reset_now();
        @(posedge clk); #1;
        repeat (4) begin clr(); s_rsn = 0; s_v = 1; step(); end
        clr(); s_v = 1; step();
        repeat (5) begin clr(); s_v = 1; s_relu = $urandom_range(0, 1); step(); end
        clr(); s_md = 1; step();
        clr(); s_v = 1; step();

        // Drain with a bounded wait
        for (int i = 0; i < 10 && (sq.size() > 0 || ldq.size() > 0); i++) begin
            clr(); step();
        end
        clr(); step();
        if (sq.size() != 0 || ldq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results and %0d layer-done pulses still pending", sq.size(), ldq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
